// File: rtl/fb_write_ctrl.sv
// Frame buffer write controller.
// Merges a non-stallable camera pixel stream with an overlay (graphics)
// write port into a single registered frame buffer write port. The camera
// always wins; the overlay only gets cycles in which the camera is idle.
// A freeze FSM blocks camera writes on frame boundaries so that a held
// frame is never torn.
module fb_write_ctrl #(
  parameter int H_PIX = 320,
  parameter int V_PIX = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cam_vsync,
  input  logic        cam_valid,
  input  logic [15:0] cam_data,
  input  logic        gfx_req,
  input  logic [16:0] gfx_addr,
  input  logic [15:0] gfx_data,
  input  logic        freeze_req,
  output logic        gfx_ack,
  output logic        we,
  output logic [16:0] wAddr,
  output logic [15:0] wData,
  output logic        frame_stop,
  output logic        frame_done,
  output logic        err
);

  localparam int          FB_DEPTH  = H_PIX * V_PIX;
  localparam logic [16:0] DEPTH_A   = 17'(FB_DEPTH);
  localparam logic [16:0] LAST_ADDR = 17'(FB_DEPTH - 1);

  // Freeze FSM: the two *_PEND states wait for a frame boundary (vsync)
  // before the freeze takes or releases effect.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STOP_PEND = 2'd1,
    STOPPED   = 2'd2,
    RUN_PEND  = 2'd3
  } frz_state_t;

  frz_state_t  state_reg, state_next;

  logic [16:0] cam_ptr_reg, cam_ptr_next;

  logic        we_reg;
  logic [16:0] waddr_reg;
  logic [15:0] wdata_reg;
  logic        gfx_ack_reg;
  logic        frame_stop_reg;
  logic        frame_done_reg;
  logic        err_reg;

  logic        write_block;
  logic        cam_in_range;
  logic [16:0] cam_addr;
  logic        cam_wr;
  logic        cam_ovf;
  logic        gfx_gnt;
  logic        gfx_in_range;
  logic        gfx_wr;
  logic        gfx_bad;

  // Arbitration and address decode for the current cycle.
  always_comb begin
    write_block  = (state_reg == STOPPED);
    // A vsync in the same cycle as a pixel restarts the frame at address 0,
    // so such a pixel is always in range.
    cam_in_range = cam_vsync || (cam_ptr_reg < DEPTH_A);
    cam_addr     = cam_vsync ? 17'd0 : cam_ptr_reg;
    cam_wr       = cam_valid && cam_in_range && !write_block;
    cam_ovf      = cam_valid && !cam_in_range;
    // The overlay is locked out in the ack cycle: a requester still holding
    // gfx_req while it sees gfx_ack must not be granted a second time.
    gfx_gnt      = gfx_req && !cam_valid && !write_block && !gfx_ack_reg;
    gfx_in_range = (gfx_addr < DEPTH_A);
    gfx_wr       = gfx_gnt && gfx_in_range;
    gfx_bad      = gfx_gnt && !gfx_in_range;
  end

  // Camera address pointer: keeps counting while writes are blocked so the
  // frame position stays in step with the sensor; saturates at FB_DEPTH.
  always_comb begin
    cam_ptr_next = cam_ptr_reg;
    if (cam_vsync) begin
      cam_ptr_next = cam_valid ? 17'd1 : 17'd0;
    end else if (cam_valid && (cam_ptr_reg < DEPTH_A)) begin
      cam_ptr_next = cam_ptr_reg + 17'd1;
    end
  end

  // Freeze FSM next-state logic; a cancelled request takes priority over a
  // coincident vsync.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RUN: begin
        if (freeze_req) state_next = STOP_PEND;
      end
      STOP_PEND: begin
        if (!freeze_req)    state_next = RUN;
        else if (cam_vsync) state_next = STOPPED;
      end
      STOPPED: begin
        if (!freeze_req) state_next = RUN_PEND;
      end
      RUN_PEND: begin
        if (freeze_req)     state_next = STOPPED;
        else if (cam_vsync) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Freeze FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Camera pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cam_ptr_reg <= 17'd0;
    end else begin
      cam_ptr_reg <= cam_ptr_next;
    end
  end

  // Registered write port; address/data hold their last value between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg    <= 1'b0;
      waddr_reg <= 17'd0;
      wdata_reg <= 16'd0;
    end else begin
      we_reg <= cam_wr || gfx_wr;
      if (cam_wr) begin
        waddr_reg <= cam_addr;
        wdata_reg <= cam_data;
      end else if (gfx_wr) begin
        waddr_reg <= gfx_addr;
        wdata_reg <= gfx_data;
      end
    end
  end

  // Handshake and status flags, aligned with the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gfx_ack_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_stop_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      gfx_ack_reg    <= gfx_gnt;
      frame_done_reg <= cam_wr && (cam_addr == LAST_ADDR);
      frame_stop_reg <= (state_reg == STOPPED) || (state_reg == RUN_PEND);
      err_reg        <= err_reg || cam_ovf || gfx_bad;
    end
  end

  assign we         = we_reg;
  assign wAddr      = waddr_reg;
  assign wData      = wdata_reg;
  assign gfx_ack    = gfx_ack_reg;
  assign frame_done = frame_done_reg;
  assign frame_stop = frame_stop_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Scoreboard bench for fb_write_ctrl: the stimulus task runs a frame-level
// reference model and queues the expected write-port events and per-cycle
// status; an independent monitor pops and compares.
module tb_fb_write_ctrl;

  localparam int DEPTH = 320 * 240;

  logic        clk;
  logic        reset;
  logic        cam_vsync;
  logic        cam_valid;
  logic [15:0] cam_data;
  logic        gfx_req;
  logic [16:0] gfx_addr;
  logic [15:0] gfx_data;
  logic        freeze_req;
  logic        gfx_ack;
  logic        we;
  logic [16:0] wAddr;
  logic [15:0] wData;
  logic        frame_stop;
  logic        frame_done;
  logic        err;

  fb_write_ctrl #(.H_PIX(320), .V_PIX(240)) dut (
    .clk        (clk),
    .reset      (reset),
    .cam_vsync  (cam_vsync),
    .cam_valid  (cam_valid),
    .cam_data   (cam_data),
    .gfx_req    (gfx_req),
    .gfx_addr   (gfx_addr),
    .gfx_data   (gfx_data),
    .freeze_req (freeze_req),
    .gfx_ack    (gfx_ack),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_stop (frame_stop),
    .frame_done (frame_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        we;
    logic [16:0] addr;
    logic [15:0] data;
    logic        ack;
    logic        done;
  } ev_t;

  typedef struct {
    logic err;
    logic fstop;
  } st_t;

  ev_t ev_q[$];
  st_t st_q[$];

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  mon_en   = 0;
  bit  verbose  = 1;
  int  done_cnt = 0;
  logic [16:0] done_addr = '0;

  // Reference model: frame position, freeze mode, sticky error, and whether
  // the overlay was granted in the previous cycle.
  int  m_ptr;
  bit  m_frozen;
  bit  m_pend;
  bit  m_err;
  bit  m_last_grant;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whatever the DUT presents against the queues.
  ev_t mon_e;
  st_t mon_s;
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (st_q.size() > 0) begin
        mon_s = st_q.pop_front();
        checks++;
        if (err !== mon_s.err || frame_stop !== mon_s.fstop) begin
          failures++;
          $display("FAIL status cyc=%0d got err=%b frame_stop=%b want err=%b frame_stop=%b",
                   cyc, err, frame_stop, mon_s.err, mon_s.fstop);
        end
      end
      if (we === 1'b1 || gfx_ack === 1'b1 || frame_done === 1'b1) begin
        if (frame_done === 1'b1) begin
          done_cnt++;
          done_addr = wAddr;
        end
        checks++;
        if (ev_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d got we=%b addr=%0d data=%h ack=%b done=%b want none",
                   cyc, we, wAddr, wData, gfx_ack, frame_done);
        end else begin
          mon_e = ev_q.pop_front();
          if (mon_e.due != cyc || we !== mon_e.we || gfx_ack !== mon_e.ack ||
              frame_done !== mon_e.done ||
              (mon_e.we && (wAddr !== mon_e.addr || wData !== mon_e.data))) begin
            failures++;
            $display("FAIL event cyc=%0d got we=%b addr=%0d data=%h ack=%b done=%b want cyc=%0d we=%b addr=%0d data=%h ack=%b done=%b",
                     cyc, we, wAddr, wData, gfx_ack, frame_done,
                     mon_e.due, mon_e.we, mon_e.addr, mon_e.data, mon_e.ack, mon_e.done);
          end else if (verbose) begin
            $display("cyc=%0d we=%b addr=%0d data=%h ack=%b done=%b ok",
                     cyc, we, wAddr, wData, gfx_ack, frame_done);
          end
        end
      end else if (ev_q.size() > 0 && ev_q[0].due <= cyc) begin
        mon_e = ev_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_event cyc=%0d got none want we=%b addr=%0d data=%h ack=%b done=%b",
                 cyc, mon_e.we, mon_e.addr, mon_e.data, mon_e.ack, mon_e.done);
      end
    end
  end

  // One clock of stimulus; the model decides what the DUT must produce.
  task automatic step(input bit vs, input bit cv, input logic [15:0] cd,
                      input bit gr, input logic [16:0] ga, input logic [15:0] gd,
                      input bit fr);
    ev_t e;
    st_t s;
    int  a;
    bit  blocked;
    bit  granted;
    @(negedge clk);
    cam_vsync  = vs;
    cam_valid  = cv;
    cam_data   = cd;
    gfx_req    = gr;
    gfx_addr   = ga;
    gfx_data   = gd;
    freeze_req = fr;

    blocked = m_frozen && !m_pend;
    granted = 0;
    e.due = cyc + 1; e.we = 0; e.addr = '0; e.data = '0; e.ack = 0; e.done = 0;
    if (cv) begin
      a = vs ? 0 : m_ptr;
      if (a < DEPTH) begin
        m_ptr = a + 1;
        if (!blocked) begin
          e.we   = 1;
          e.addr = a[16:0];
          e.data = cd;
          e.done = (a == DEPTH - 1);
        end
      end else begin
        m_err = 1;
      end
    end else begin
      if (vs) m_ptr = 0;
      if (gr && !blocked && !m_last_grant) begin
        granted = 1;
        e.ack   = 1;
        if (ga < DEPTH) begin
          e.we   = 1;
          e.addr = ga;
          e.data = gd;
        end else begin
          m_err = 1;
        end
      end
    end
    m_last_grant = granted;
    if (e.we || e.ack || e.done) ev_q.push_back(e);
    s.err   = m_err;
    s.fstop = m_frozen;
    st_q.push_back(s);

    // Freeze mode: a mismatch between request and mode arms a change that
    // completes at the next vsync, or is cancelled if the request reverts.
    if (!m_pend) begin
      if (fr != m_frozen) m_pend = 1;
    end else if (fr == m_frozen) begin
      m_pend = 0;
    end else if (vs) begin
      m_frozen = !m_frozen;
      m_pend   = 0;
    end
  endtask

  task automatic idle(input bit fr);
    step(0, 0, 16'h0, 0, 17'h0, 16'h0, fr);
  endtask

  task automatic pixels(input int n, input bit fr);
    for (int i = 0; i < n; i++) step(0, 1, 16'($urandom), 0, 17'h0, 16'h0, fr);
  endtask

  // Assert reset mid-cycle, confirm every output clears at once, then release.
  task automatic do_reset(input string tag);
    logic [53:0] outs;
    @(negedge clk);
    mon_en     = 0;
    reset      = 1;
    cam_vsync  = 0;
    cam_valid  = 0;
    cam_data   = '0;
    gfx_req    = 0;
    gfx_addr   = '0;
    gfx_data   = '0;
    freeze_req = 0;
    #1;
    outs = {we, wAddr, wData, gfx_ack, frame_stop, frame_done, err};
    checks++;
    if (outs !== 54'd0) begin
      failures++;
      $display("FAIL reset_outputs_%s got we=%b addr=%0d data=%h ack=%b stop=%b done=%b err=%b want all 0",
               tag, we, wAddr, wData, gfx_ack, frame_stop, frame_done, err);
    end else begin
      $display("reset %s outputs all zero", tag);
    end
    repeat (2) @(posedge clk);
    ev_q.delete();
    st_q.delete();
    m_ptr = 0; m_frozen = 0; m_pend = 0; m_err = 0; m_last_grant = 0;
    @(negedge clk);
    reset  = 0;
    mon_en = 1;
  endtask

  task automatic drain_check(input string tag);
    idle(0);
    idle(0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (ev_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s got %0d outstanding events want 0", tag, ev_q.size());
    end
  endtask

  logic [16:0] g_a;
  logic [15:0] g_d;
  bit          g_req;
  bit          frz;

  initial begin
    reset      = 1;
    cam_vsync  = 0;
    cam_valid  = 0;
    cam_data   = '0;
    gfx_req    = 0;
    gfx_addr   = '0;
    gfx_data   = '0;
    freeze_req = 0;
    repeat (2) @(posedge clk);

    // Full frame, then camera overflow.
    do_reset("initial");
    verbose  = 0;
    done_cnt = 0;
    idle(0);
    step(1, 0, 16'h0, 0, 17'h0, 16'h0, 0);
    pixels(DEPTH, 0);
    verbose = 1;
    pixels(3, 0);
    drain_check("frame");
    checks++;
    if (done_cnt != 1 || done_addr !== 17'(DEPTH - 1)) begin
      failures++;
      $display("FAIL frame_done got count=%0d addr=%0d want count=1 addr=%0d",
               done_cnt, done_addr, DEPTH - 1);
    end else begin
      $display("frame_done once at addr %0d", done_addr);
    end

    // Overlay arbitration, out-of-range overlay, held request.
    do_reset("overlay");
    step(1, 1, 16'h1111, 0, 17'h0, 16'h0, 0);
    pixels(4, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 16'($urandom), 1, 17'd100, 16'hF800, 0);
    for (int i = 0; i < 4 && !m_last_grant; i++) step(0, 0, 16'h0, 1, 17'd100, 16'hF800, 0);
    idle(0);
    idle(0);
    step(0, 0, 16'h0, 1, 17'(DEPTH), 16'hABCD, 0);
    idle(0);
    step(0, 0, 16'h0, 1, 17'd200, 16'h1234, 0);
    step(0, 0, 16'h0, 1, 17'd300, 16'h5678, 0);
    step(0, 0, 16'h0, 1, 17'd300, 16'h5678, 0);
    step(0, 1, 16'h0BAD, 1, 17'd400, 16'h9999, 0);
    step(0, 0, 16'h0, 1, 17'd400, 16'h9999, 0);
    drain_check("overlay");

    // Freeze sequence, ending with an asynchronous reset while STOPPED.
    do_reset("freeze");
    step(1, 1, 16'h2222, 0, 17'h0, 16'h0, 0);
    pixels(20, 0);
    pixels(10, 1);
    idle(1);
    step(0, 0, 16'h0, 1, 17'd50, 16'h5050, 1);
    idle(1);
    pixels(10, 1);
    step(1, 1, 16'h3333, 0, 17'h0, 16'h0, 1);
    pixels(10, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1, 17'd60, 16'h6060, 1);
    pixels(8, 0);
    pixels(3, 1);
    pixels(5, 0);
    idle(0);
    step(1, 1, 16'h4444, 0, 17'h0, 16'h0, 0);
    pixels(10, 0);
    pixels(5, 1);
    step(1, 0, 16'h0, 0, 17'h0, 16'h0, 1);
    pixels(10, 1);
    do_reset("stopped");
    step(1, 0, 16'h0, 0, 17'h0, 16'h0, 0);
    pixels(6, 0);
    drain_check("freeze");

    // Randomised traffic.
    do_reset("random");
    verbose = 0;
    g_req = 0;
    frz   = 0;
    g_a   = '0;
    g_d   = '0;
    for (int i = 0; i < 2000; i++) begin
      if (m_last_grant) begin
        g_req = ($urandom_range(0, 1) == 1);
        g_a   = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(DEPTH, 131071))
                                            : 17'($urandom_range(0, DEPTH - 1));
        g_d   = 16'($urandom);
      end else if (!g_req && $urandom_range(0, 3) == 0) begin
        g_req = 1;
        g_a   = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(DEPTH, 131071))
                                            : 17'($urandom_range(0, DEPTH - 1));
        g_d   = 16'($urandom);
      end
      if ($urandom_range(0, 149) == 0) frz = !frz;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 16'($urandom),
           g_req, g_a, g_d, frz);
    end
    verbose = 1;
    drain_check("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
